// File: rtl/ex_operand_stage_if.sv
// Operand-stage bus: decode-side handshake, forwarding buses, and ALU-side outputs.
// The package carries the ALU operation encoding shared by the stage and its neighbours.
package ex_operand_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alufunc_t;
endpackage

interface ex_operand_stage_if;
  import ex_operand_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [63:0] in_imm;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic [63:0] in_rs1_data;
  logic [63:0] in_rs2_data;
  logic        in_use_pc;
  logic        in_use_imm;
  logic        in_wen;
  alufunc_t    in_alufunc;
  logic        flush;

  logic        fwd_mem_valid;
  logic [4:0]  fwd_mem_rd;
  logic [63:0] fwd_mem_data;
  logic        fwd_wb_valid;
  logic [4:0]  fwd_wb_rd;
  logic [63:0] fwd_wb_data;

  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic [63:0] out_store_data;
  alufunc_t    out_alufunc;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [63:0] out_pc;
  logic        hazard_stall;

  modport slave (
    input  in_valid, in_pc, in_imm, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data,
           in_use_pc, in_use_imm, in_wen, in_alufunc, flush,
           fwd_mem_valid, fwd_mem_rd, fwd_mem_data, fwd_wb_valid, fwd_wb_rd, fwd_wb_data,
           out_ready,
    output in_ready, out_valid, out_a, out_b, out_store_data, out_alufunc, out_rd,
           out_wen, out_pc, hazard_stall
  );

  modport master (
    output in_valid, in_pc, in_imm, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data,
           in_use_pc, in_use_imm, in_wen, in_alufunc, flush,
           fwd_mem_valid, fwd_mem_rd, fwd_mem_data, fwd_wb_valid, fwd_wb_rd, fwd_wb_data,
           out_ready,
    input  in_ready, out_valid, out_a, out_b, out_store_data, out_alufunc, out_rd,
           out_wen, out_pc, hazard_stall
  );
endinterface

// File: rtl/ex_operand_stage.sv
// Single-entry execute operand stage: holds one decoded instruction and builds ALU operands.
// Define FORWARD_EN to forward MEM/WB results; otherwise RAW hazards stall via hazard_stall.
module ex_operand_stage
  import ex_operand_pkg::*;
(
  input logic clk,
  input logic reset,
  ex_operand_stage_if.slave bus
);

  logic        valid_q, valid_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] imm_q, imm_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] rs1_data_q, rs1_data_d;
  logic [63:0] rs2_data_q, rs2_data_d;
  logic        use_pc_q, use_pc_d;
  logic        use_imm_q, use_imm_d;
  logic        wen_q, wen_d;
  alufunc_t    alufunc_q, alufunc_d;

  logic        mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic [63:0] src1, src2;
  logic        hazard, retire, ready, capture;

  // Register x0 is hardwired to zero, so a bus writing x0 never supplies a value.
  assign mem_hit1 = bus.fwd_mem_valid && (bus.fwd_mem_rd == rs1_q) && (rs1_q != 5'd0);
  assign mem_hit2 = bus.fwd_mem_valid && (bus.fwd_mem_rd == rs2_q) && (rs2_q != 5'd0);
  assign wb_hit1  = bus.fwd_wb_valid  && (bus.fwd_wb_rd  == rs1_q) && (rs1_q != 5'd0);
  assign wb_hit2  = bus.fwd_wb_valid  && (bus.fwd_wb_rd  == rs2_q) && (rs2_q != 5'd0);

`ifdef FORWARD_EN
  assign src1   = mem_hit1 ? bus.fwd_mem_data : (wb_hit1 ? bus.fwd_wb_data : rs1_data_q);
  assign src2   = mem_hit2 ? bus.fwd_mem_data : (wb_hit2 ? bus.fwd_wb_data : rs2_data_q);
  assign hazard = 1'b0;
`else
  logic rs1_used, rs2_used;
  logic unused_fwd_mem_data;

  // rs2 still matters for a store even when the ALU takes the immediate.
  assign rs1_used = !use_pc_q;
  assign rs2_used = !use_imm_q || !wen_q;
  assign src1     = rs1_data_q;
  assign src2     = rs2_data_q;
  assign hazard   = valid_q && ((rs1_used && (mem_hit1 || wb_hit1)) ||
                                (rs2_used && (mem_hit2 || wb_hit2)));
  assign unused_fwd_mem_data = ^bus.fwd_mem_data;
`endif

  assign retire  = valid_q && !hazard && bus.out_ready;
  assign ready   = !valid_q || retire;
  assign capture = bus.in_valid && ready;

  assign bus.in_ready       = ready;
  assign bus.out_valid      = valid_q && !hazard;
  assign bus.hazard_stall   = hazard;
  assign bus.out_a          = use_pc_q  ? pc_q  : src1;
  assign bus.out_b          = use_imm_q ? imm_q : src2;
  assign bus.out_store_data = src2;
  assign bus.out_alufunc    = alufunc_q;
  assign bus.out_rd         = rd_q;
  assign bus.out_wen        = wen_q;
  assign bus.out_pc         = pc_q;

  // Flush beats capture and retire; a held entry absorbs WB writes so its operands stay current.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    use_pc_d   = use_pc_q;
    use_imm_d  = use_imm_q;
    wen_d      = wen_q;
    alufunc_d  = alufunc_q;

    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d    = 1'b1;
      pc_d       = bus.in_pc;
      imm_d      = bus.in_imm;
      rs1_d      = bus.in_rs1;
      rs2_d      = bus.in_rs2;
      rd_d       = bus.in_rd;
      rs1_data_d = bus.in_rs1_data;
      rs2_data_d = bus.in_rs2_data;
      use_pc_d   = bus.in_use_pc;
      use_imm_d  = bus.in_use_imm;
      wen_d      = bus.in_wen;
      alufunc_d  = bus.in_alufunc;
    end else if (retire) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      if (wb_hit1) rs1_data_d = bus.fwd_wb_data;
      if (wb_hit2) rs2_data_d = bus.fwd_wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      pc_q       <= 64'd0;
      imm_q      <= 64'd0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      rd_q       <= 5'd0;
      rs1_data_q <= 64'd0;
      rs2_data_q <= 64'd0;
      use_pc_q   <= 1'b0;
      use_imm_q  <= 1'b0;
      wen_q      <= 1'b0;
      alufunc_q  <= ALU_ADD;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      use_pc_q   <= use_pc_d;
      use_imm_q  <= use_imm_d;
      wen_q      <= wen_d;
      alufunc_q  <= alufunc_d;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: expected operands are queued on capture and
// compared when the stage retires. FORWARD_EN selects the forwarding or stalling scenarios.
module tb_ex_operand_stage;
  import ex_operand_pkg::*;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] store;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic        wen;
    logic [3:0]  func;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   check_count = 0;
  int   error_count = 0;
  int   cycle_count = 0;
  exp_t sb[$];
  int   retire_cycles[$];
  exp_t mon_e;

  ex_operand_stage_if bus();

  ex_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_count <= cycle_count + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Retirements are checked against the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      retire_cycles.push_back(cycle_count);
      if (sb.size() == 0) begin
        checkOutput("sb_has_entry", 64'(sb.size()), 64'd1);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("out_a", bus.out_a, mon_e.a);
        checkOutput("out_b", bus.out_b, mon_e.b);
        checkOutput("out_store_data", bus.out_store_data, mon_e.store);
        checkOutput("out_pc", bus.out_pc, mon_e.pc);
        checkOutput("out_rd", 64'(bus.out_rd), 64'(mon_e.rd));
        checkOutput("out_wen", 64'(bus.out_wen), 64'(mon_e.wen));
        checkOutput("out_alufunc", 64'(bus.out_alufunc), 64'(mon_e.func));
      end
    end
  end

  task automatic applyStimulus(input logic [63:0] pc, input logic [63:0] imm,
                               input logic [63:0] r1d, input logic [63:0] r2d,
                               input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                               input logic upc, input logic uimm, input logic wen,
                               input int func);
    int   waits;
    exp_t e;
    waits = 0;
    bus.in_valid    = 1'b1;
    bus.in_pc       = pc;
    bus.in_imm      = imm;
    bus.in_rs1_data = r1d;
    bus.in_rs2_data = r2d;
    bus.in_rs1      = r1;
    bus.in_rs2      = r2;
    bus.in_rd       = rd;
    bus.in_use_pc   = upc;
    bus.in_use_imm  = uimm;
    bus.in_wen      = wen;
    bus.in_alufunc  = alufunc_t'(func[3:0]);
    @(negedge clk);
    while (!bus.in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    checkOutput("in_ready_before_capture", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    e.a     = upc ? pc : r1d;
    e.b     = uimm ? imm : r2d;
    e.store = r2d;
    e.pc    = pc;
    e.rd    = rd;
    e.wen   = wen;
    e.func  = func[3:0];
    sb.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_pc = '0; bus.in_imm = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0;
    bus.in_rs1_data = '0; bus.in_rs2_data = '0;
    bus.in_use_pc = 1'b0; bus.in_use_imm = 1'b0; bus.in_wen = 1'b0;
    bus.in_alufunc = ALU_ADD;
    bus.flush = 1'b0;
    bus.fwd_mem_valid = 1'b0; bus.fwd_mem_rd = '0; bus.fwd_mem_data = '0;
    bus.fwd_wb_valid = 1'b0; bus.fwd_wb_rd = '0; bus.fwd_wb_data = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_hazard", 64'(bus.hazard_stall), 64'd0);
    checkOutput("rst_out_a", bus.out_a, 64'd0);
    checkOutput("rst_out_b", bus.out_b, 64'd0);
    checkOutput("rst_store", bus.out_store_data, 64'd0);
    checkOutput("rst_pc", bus.out_pc, 64'd0);
    checkOutput("rst_rd_wen", 64'({bus.out_rd, bus.out_wen}), 64'd0);
    checkOutput("rst_alufunc", 64'(bus.out_alufunc), 64'd0);
    reset = 1'b0;
    nextCycle();

    // Eight back-to-back instructions, no forwarding traffic.
    retire_cycles.delete();
    for (int i = 0; i < 8; i++) begin
      applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom}, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 9));
    end
    bus.in_valid = 1'b0;
    repeat (3) nextCycle();
    checkOutput("b2b_retire_count", 64'(retire_cycles.size()), 64'd8);
    if (retire_cycles.size() == 8)
      checkOutput("b2b_retire_span", 64'(retire_cycles[7] - retire_cycles[0]), 64'd7);
    checkOutput("b2b_sb_drained", 64'(sb.size()), 64'd0);

    // Held entry picks up a one-cycle WB write to rs1.
    bus.out_ready = 1'b0;
    applyStimulus(64'h1000, 64'h8, 64'h11, 64'h22, 5'd3, 5'd4, 5'd6, 1'b0, 1'b1, 1'b1, 0);
    bus.in_valid = 1'b0;
    bus.fwd_wb_valid = 1'b1; bus.fwd_wb_rd = 5'd3; bus.fwd_wb_data = 64'h42;
    @(negedge clk);
`ifdef FORWARD_EN
    checkOutput("wb_hold_c1_a", bus.out_a, 64'h42);
`else
    checkOutput("wb_hold_c1_hazard", 64'(bus.hazard_stall), 64'd1);
`endif
    nextCycle();
    bus.fwd_wb_valid = 1'b0;
    @(negedge clk);
    checkOutput("wb_hold_c2_a", bus.out_a, 64'h42);
    checkOutput("wb_hold_c2_valid", 64'(bus.out_valid), 64'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("wb_hold_c3_a", bus.out_a, 64'h42);
    sb[sb.size() - 1].a = 64'h42;
    nextCycle();
    bus.out_ready = 1'b1;
    repeat (2) nextCycle();
    checkOutput("wb_hold_sb_drained", 64'(sb.size()), 64'd0);

`ifdef FORWARD_EN
    // MEM wins over WB for the same register.
    bus.out_ready = 1'b0;
    applyStimulus(64'h2000, 64'h4, 64'h10, 64'h2, 5'd5, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1);
    bus.in_valid = 1'b0;
    bus.fwd_mem_valid = 1'b1; bus.fwd_mem_rd = 5'd5; bus.fwd_mem_data = 64'h99;
    bus.fwd_wb_valid = 1'b1;  bus.fwd_wb_rd = 5'd5;  bus.fwd_wb_data = 64'h77;
    @(negedge clk);
    checkOutput("fwd_mem_priority_a", bus.out_a, 64'h99);
    checkOutput("fwd_hazard_zero", 64'(bus.hazard_stall), 64'd0);
    nextCycle();
    bus.fwd_mem_valid = 1'b0; bus.fwd_wb_valid = 1'b0;
    sb[sb.size() - 1].a = 64'h77;
    bus.out_ready = 1'b1;
    repeat (2) nextCycle();

    // x0 is never forwarded.
    applyStimulus(64'h3000, 64'h4, 64'h1, 64'h0, 5'd1, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1, 2);
    bus.in_valid = 1'b0;
    bus.fwd_mem_valid = 1'b1; bus.fwd_mem_rd = 5'd0; bus.fwd_mem_data = 64'hFF;
    @(negedge clk);
    checkOutput("x0_no_fwd_b", bus.out_b, 64'd0);
    nextCycle();
    bus.fwd_mem_valid = 1'b0;
    repeat (2) nextCycle();
`else
    // MEM then WB on rs1: two stall cycles, then release with the written value.
    applyStimulus(64'h2000, 64'h4, 64'h1, 64'h2, 5'd7, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1);
    bus.in_valid = 1'b0;
    bus.fwd_mem_valid = 1'b1; bus.fwd_mem_rd = 5'd7; bus.fwd_mem_data = 64'h99;
    sb[sb.size() - 1].a = 64'h5;
    @(negedge clk);
    checkOutput("raw_c0_hazard", 64'(bus.hazard_stall), 64'd1);
    checkOutput("raw_c0_out_valid", 64'(bus.out_valid), 64'd0);
    nextCycle();
    bus.fwd_mem_valid = 1'b0;
    bus.fwd_wb_valid = 1'b1; bus.fwd_wb_rd = 5'd7; bus.fwd_wb_data = 64'h5;
    @(negedge clk);
    checkOutput("raw_c1_hazard", 64'(bus.hazard_stall), 64'd1);
    nextCycle();
    bus.fwd_wb_valid = 1'b0;
    @(negedge clk);
    checkOutput("raw_c2_hazard", 64'(bus.hazard_stall), 64'd0);
    checkOutput("raw_c2_out_valid", 64'(bus.out_valid), 64'd1);
    nextCycle();

    // A store uses rs2 even with the immediate selected.
    applyStimulus(64'h2100, 64'h10, 64'h0, 64'h33, 5'd0, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0, 0);
    bus.in_valid = 1'b0;
    bus.fwd_mem_valid = 1'b1; bus.fwd_mem_rd = 5'd9; bus.fwd_mem_data = 64'h99;
    sb[sb.size() - 1].store = 64'h44;
    @(negedge clk);
    checkOutput("store_rs2_hazard", 64'(bus.hazard_stall), 64'd1);
    nextCycle();
    bus.fwd_mem_valid = 1'b0;
    bus.fwd_wb_valid = 1'b1; bus.fwd_wb_rd = 5'd9; bus.fwd_wb_data = 64'h44;
    nextCycle();
    bus.fwd_wb_valid = 1'b0;
    repeat (2) nextCycle();

    // rs2 replaced by the immediate on a register-writing op is not a hazard.
    applyStimulus(64'h2200, 64'h10, 64'h0, 64'h33, 5'd0, 5'd9, 5'd4, 1'b1, 1'b1, 1'b1, 3);
    bus.in_valid = 1'b0;
    bus.fwd_mem_valid = 1'b1; bus.fwd_mem_rd = 5'd9;
    @(negedge clk);
    checkOutput("unused_rs2_hazard", 64'(bus.hazard_stall), 64'd0);
    nextCycle();
    bus.fwd_mem_valid = 1'b0;

    // Register x0 never matches a bus.
    applyStimulus(64'h2300, 64'h10, 64'hAB, 64'h1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b1, 1'b1, 4);
    bus.in_valid = 1'b0;
    bus.fwd_mem_valid = 1'b1; bus.fwd_mem_rd = 5'd0; bus.fwd_mem_data = 64'hFF;
    @(negedge clk);
    checkOutput("x0_hazard", 64'(bus.hazard_stall), 64'd0);
    nextCycle();
    bus.fwd_mem_valid = 1'b0;
    repeat (2) nextCycle();
`endif
    checkOutput("hazard_sb_drained", 64'(sb.size()), 64'd0);

    // Flush together with a capture drops the incoming entry.
    bus.in_valid = 1'b1; bus.in_pc = 64'hDEAD; bus.in_use_pc = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_cap_in_ready_pre", 64'(bus.in_ready), 64'd1);
    nextCycle();
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_cap_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("flush_cap_in_ready", 64'(bus.in_ready), 64'd1);
    nextCycle();

    // Flush of a held entry.
    bus.out_ready = 1'b0;
    applyStimulus(64'h4000, 64'h1, 64'h2, 64'h3, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5);
    void'(sb.pop_back());
    bus.in_valid = 1'b0;
    bus.flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_held_pre_valid", 64'(bus.out_valid), 64'd1);
    nextCycle();
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("flush_held_out_valid", 64'(bus.out_valid), 64'd0);
    nextCycle();

    // Asynchronous reset mid-operation discards the held entry.
    bus.out_ready = 1'b0;
    applyStimulus(64'h5000, 64'h1, 64'h2, 64'h3, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 6);
    void'(sb.pop_back());
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_pre_a", bus.out_a, 64'h5000);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("mid_rst_out_a", bus.out_a, 64'd0);
    checkOutput("mid_rst_out_pc", bus.out_pc, 64'd0);
    nextCycle();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) nextCycle();
    checkOutput("final_sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk, reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 in_valid / in_ready  in / out  1 / 1  decode-side handshake.
REQ-005 in_pc, in_imm  in  64 each  instruction PC; sign-extended immediate.
REQ-006 in_rs1, in_rs2, in_rd  in  5 each  source and destination register indices.
REQ-007 in_rs1_data, in_rs2_data  in  64 each  register-file read data.
REQ-008 in_use_pc, in_use_imm, in_wen  in  1 each  A=PC select; B=imm select; rd write enable.
REQ-009 in_alufunc  in  alufunc_t  ALU operation.
REQ-010 flush  in  1  kill held entry (branch redirect).
REQ-011 fwd_mem_valid, fwd_mem_rd, fwd_mem_data  in  1/5/64  MEM-stage result bus.
REQ-012 fwd_wb_valid, fwd_wb_rd, fwd_wb_data  in  1/5/64  WB register-write bus.
REQ-013 out_valid / out_ready  out / in  1 / 1  ALU-side handshake.
REQ-014 out_a, out_b, out_store_data  out  64 each  ALU operands a and b; forwarded rs2 value.
REQ-015 out_alufunc, out_rd, out_wen, out_pc  out  alufunc_t/5/1/64  passthrough fields.
REQ-016 hazard_stall  out  1  held entry blocked by an unresolved RAW hazard.

Function
REQ-017 SHALL hold one entry (valid bit plus all in_* fields); in_ready = !valid || (out_valid && out_ready).
REQ-018 SHALL capture in_* at the clock edge when in_valid && in_ready; latency capture-to-out_valid is 1 cycle.
REQ-019 SHALL clear valid when out_valid && out_ready and no capture occurs in the same cycle; simultaneous retire and capture loads the new entry (back-to-back, full throughput).
REQ-020 flush SHALL clear valid at the next edge and take priority over capture and retire in the same cycle.
REQ-021 A bus matches a source when bus valid, bus rd == stored rs, and rs != 0; x0 SHALL never match.
REQ-022 Forwarded rsN = MEM data if MEM matches, else WB data if WB matches, else stored rsN data (MEM has priority).
REQ-023 While valid and not retiring, SHALL overwrite stored rsN data with fwd_wb_data on a WB match, so held operands survive producer retirement.
REQ-024 out_a = in_use_pc ? pc : forwarded rs1; out_b = in_use_imm ? imm : forwarded rs2; out_store_data = forwarded rs2; all combinational from the held entry.
REQ-025 out_valid = valid && !hazard_stall; passthrough outputs are driven from the held entry regardless of out_valid.
REQ-026 Data output values SHALL be don't-care-free: when valid = 0, outputs show the last held entry (zero after reset).

Reset
REQ-027 reset SHALL immediately clear valid and all stored fields to 0; out_valid = 0, in_ready = 1, hazard_stall = 0, all data outputs 0, out_alufunc = encoding 0.
REQ-028 Reset asserted mid-operation SHALL discard the held entry; no retire occurs on that cycle.

Configuration
REQ-029 Macro FORWARD_EN: defined -> REQ-022 forwarding active; hazard_stall is constant 0.
REQ-030 Without FORWARD_EN: out_a/out_b/out_store_data use stored data only; hazard_stall = valid && (MEM or WB match on any used source); REQ-023 refresh still applies, so the entry releases one cycle after the WB write.
REQ-031 A source is used unless replaced by PC/imm; rs2 is also used when in_wen = 0 (store).

Verification
REQ-032 FORWARD_EN: hold rs1=5 (data 0x10), MEM rd=5 data 0x99, WB rd=5 data 0x77 -> out_a = 0x99.
REQ-033 FORWARD_EN: rs2=0, MEM rd=0 data 0xFF, stored 0 -> out_b = 0, no forwarding.
REQ-034 out_ready=0 for 3 cycles, WB rd=3 data 0x42 in cycle 1 only, rs1=3 -> cycles 2-3 out_a = 0x42.
REQ-035 Continuous in_valid/out_ready=1 for 8 instructions -> 8 retires in 8 consecutive cycles, in order.
REQ-036 flush together with in_valid && in_ready -> next cycle out_valid = 0, in_ready = 1, entry dropped.
REQ-037 No FORWARD_EN: rs1=7, MEM rd=7 then WB rd=7 data 0x5 on next cycle -> hazard_stall=1 for 2 cycles, then out_valid=1, out_a=0x5.
